// File: rtl/line_memory_backend.sv
// Whole-line data memory behind the dcache: one 256-bit line read or write per request,
// acknowledged with a single-cycle pulse a fixed LATENCY cycles after acceptance.
module line_memory_backend #(
  parameter int unsigned LINES   = 512,
  parameter int unsigned LINE_W  = 256,
  parameter int unsigned LATENCY = 10
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [31:0]       addr_i,
  input  logic [LINE_W-1:0] data_i,
  input  logic              enable_i,
  input  logic              write_i,
  output logic              ack_o,
  output logic [LINE_W-1:0] data_o
);

  localparam int unsigned IdxW = $clog2(LINES);
  localparam int unsigned CntW = $clog2(LATENCY);
  localparam logic [CntW-1:0] CntLast = CntW'(LATENCY - 1);

  typedef enum logic {StIdle, StWait} state_e;

  // Not reset: contents survive reset and may be preloaded from outside.
  logic [LINE_W-1:0] memory [0:LINES-1];

  state_e            state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [IdxW-1:0]   idx_q;
  logic [LINE_W-1:0] wdata_q;
  logic              wr_q;
  logic              accept;

  // Byte offset and high address bits never select anything.
  logic unused_addr;
  assign unused_addr = ^{addr_i[31:IdxW+5], addr_i[4:0]};

  assign accept = (state_q == StIdle) && enable_i;
  assign ack_o  = (state_q == StWait) && (cnt_q == CntLast);
  assign data_o = memory[idx_q];

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StIdle: begin
        if (enable_i) begin
          state_d = StWait;
          cnt_d   = '0;
        end
      end
      StWait: begin
        if (cnt_q == CntLast) begin
          state_d = StIdle;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      idx_q   <= '0;
      wdata_q <= '0;
      wr_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (accept) begin
        idx_q   <= addr_i[IdxW+4:5];
        wdata_q <= data_i;
        wr_q    <= write_i;
      end
    end
  end

  // The line is committed at the edge that ends the ack cycle; reset aborts it.
  always_ff @(posedge clk_i) begin
    if (rst_i && ack_o && wr_q) begin
      memory[idx_q] <= wdata_q;
    end
  end

endmodule

// File: tb/tb_line_memory_backend.sv
// Randomised self-checking bench for line_memory_backend against an array-based line model.
module tb_line_memory_backend;

  localparam int LAT = 10;

  logic         clk = 1'b0;
  logic         rst;
  logic [31:0]  addr;
  logic [255:0] data;
  logic         enable;
  logic         write;
  logic         ack;
  logic [255:0] rdata;

  logic [255:0] ref_mem [0:511];
  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  line_memory_backend dut (
    .clk_i   (clk),
    .rst_i   (rst),
    .addr_i  (addr),
    .data_i  (data),
    .enable_i(enable),
    .write_i (write),
    .ack_o   (ack),
    .data_o  (rdata)
  );

  function automatic logic [255:0] rand_line();
    logic [255:0] v;
    for (int i = 0; i < 8; i++) v[i*32 +: 32] = $urandom;
    return v;
  endfunction

  function automatic int line_of(input logic [31:0] a);
    return int'(a[13:5]);
  endfunction

  task automatic preload(input int line, input logic [255:0] v);
    dut.memory[line] = v;
    ref_mem[line]    = v;
  endtask

  // Issues one request, scrambles the inputs while it is in flight, and returns the number
  // of cycles until ack (-1 on timeout) and data_o seen in the ack cycle. Ends at the
  // falling edge inside the ack cycle.
  task automatic run_req(input logic [31:0] a, input logic [255:0] d, input logic w,
                         output int lat, output logic [255:0] rd);
    @(negedge clk);
    addr = a; data = d; write = w; enable = 1'b1;
    @(posedge clk);
    #1;
    enable = 1'b0; addr = $urandom; data = rand_line(); write = ~w;
    lat = -1;
    rd  = '0;
    for (int c = 1; c <= 3 * LAT; c++) begin
      @(negedge clk);
      if (ack) begin
        lat = c;
        rd  = rdata;
        break;
      end
    end
  endtask

  task automatic test_reset();
    int lat;
    logic [255:0] rd;
    preload(0, 256'h5);
    rst = 1'b0; enable = 1'b0; write = 1'b0; addr = '0; data = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_cmp++;
    if (ack !== 1'b0) begin n_err++; $display("FAIL reset_ack got %b want 0", ack); end
    rst = 1'b1;
    run_req(32'h0, '0, 1'b0, lat, rd);
    n_cmp++;
    if (lat !== LAT) begin n_err++; $display("FAIL first_read_latency got %0d want %0d", lat, LAT); end
    n_cmp++;
    if (rd !== 256'h5) begin n_err++; $display("FAIL first_read_data got %h want 5", rd); end
    @(negedge clk);
    n_cmp++;
    if (ack !== 1'b0) begin n_err++; $display("FAIL ack_single_pulse got %b want 0", ack); end
  endtask

  task automatic test_write();
    int lat;
    logic [255:0] rd;
    logic [255:0] pat;
    pat = {8{32'hDEADBEEF}};
    run_req(32'h400, pat, 1'b1, lat, rd);
    n_cmp++;
    if (lat !== LAT) begin n_err++; $display("FAIL write_latency got %0d want %0d", lat, LAT); end
    n_cmp++;
    if (dut.memory[32] !== ref_mem[32]) begin
      n_err++; $display("FAIL write_before_edge got %h want %h", dut.memory[32], ref_mem[32]);
    end
    @(posedge clk);
    #1;
    ref_mem[32] = pat;
    n_cmp++;
    if (dut.memory[32] !== pat) begin
      n_err++; $display("FAIL write_after_edge got %h want %h", dut.memory[32], pat);
    end
    run_req(32'h400, '0, 1'b0, lat, rd);
    n_cmp++;
    if (rd !== pat) begin n_err++; $display("FAIL read_after_write got %h want %h", rd, pat); end
  endtask

  task automatic test_alias();
    int lat;
    logic [255:0] rd;
    run_req(32'h4020, 256'h1234, 1'b1, lat, rd);
    @(posedge clk);
    #1;
    ref_mem[1] = 256'h1234;
    n_cmp++;
    if (dut.memory[1] !== 256'h1234) begin
      n_err++; $display("FAIL alias_write got %h want 1234", dut.memory[1]);
    end
    run_req(32'h0020, '0, 1'b0, lat, rd);
    n_cmp++;
    if (rd !== 256'h1234) begin n_err++; $display("FAIL alias_read_20 got %h want 1234", rd); end
    run_req(32'h003F, '0, 1'b0, lat, rd);
    n_cmp++;
    if (rd !== 256'h1234) begin n_err++; $display("FAIL alias_read_3f got %h want 1234", rd); end
  endtask

  task automatic test_back_to_back();
    int ack_cyc [$];
    int nxt;
    @(negedge clk);
    addr = 32'h0; write = 1'b0; enable = 1'b1; data = rand_line();
    nxt = 0;
    for (int c = 0; c < 60; c++) begin
      @(negedge clk);
      data = rand_line();
      if (ack) begin
        ack_cyc.push_back(c);
        n_cmp++;
        if (rdata !== ref_mem[nxt]) begin
          n_err++; $display("FAIL b2b_data line %0d got %h want %h", nxt, rdata, ref_mem[nxt]);
        end
        nxt  = 1 - nxt;
        addr = (nxt == 1) ? 32'h20 : 32'h0;
      end
    end
    enable = 1'b0;
    n_cmp++;
    if (ack_cyc.size() < 4) begin
      n_err++; $display("FAIL b2b_ack_count got %0d want >=4", ack_cyc.size());
    end
    for (int i = 1; i < ack_cyc.size(); i++) begin
      n_cmp++;
      if (ack_cyc[i] - ack_cyc[i-1] !== LAT + 1) begin
        n_err++; $display("FAIL b2b_spacing got %0d want %0d", ack_cyc[i] - ack_cyc[i-1], LAT + 1);
      end
    end
    // Let any request accepted on the last cycle finish before the next test.
    repeat (2 * LAT) @(negedge clk);
  endtask

  task automatic test_random();
    int lat;
    logic [255:0] rd;
    logic [31:0] a;
    logic [255:0] d;
    logic w;
    int ln;
    for (int i = 0; i < 20; i++) begin
      a = $urandom; d = rand_line(); w = 1'($urandom_range(0, 1));
      ln = line_of(a);
      run_req(a, d, w, lat, rd);
      n_cmp++;
      if (lat !== LAT) begin n_err++; $display("FAIL rand_latency got %0d want %0d", lat, LAT); end
      if (!w) begin
        n_cmp++;
        if (rd !== ref_mem[ln]) begin
          n_err++; $display("FAIL rand_read line %0d got %h want %h", ln, rd, ref_mem[ln]);
        end
      end
      @(posedge clk);
      #1;
      if (w) ref_mem[ln] = d;
      n_cmp++;
      if (dut.memory[ln] !== ref_mem[ln]) begin
        n_err++; $display("FAIL rand_mem line %0d got %h want %h", ln, dut.memory[ln], ref_mem[ln]);
      end
    end
  endtask

  task automatic test_reset_abort();
    int lat;
    int acks;
    logic [255:0] rd;
    preload(7, 256'hA);
    @(negedge clk);
    addr = 32'h7 << 5; data = rand_line(); write = 1'b1; enable = 1'b1;
    @(posedge clk);
    #1;
    enable = 1'b0;
    repeat (5) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    acks = 0;
    for (int c = 0; c < 2 * LAT; c++) begin
      @(negedge clk);
      if (ack) acks++;
    end
    n_cmp++;
    if (acks !== 0) begin n_err++; $display("FAIL abort_acks got %0d want 0", acks); end
    n_cmp++;
    if (dut.memory[7] !== 256'hA) begin
      n_err++; $display("FAIL abort_mem got %h want a", dut.memory[7]);
    end
    run_req(32'h7 << 5, '0, 1'b0, lat, rd);
    n_cmp++;
    if (lat !== LAT) begin n_err++; $display("FAIL post_abort_latency got %0d want %0d", lat, LAT); end
    n_cmp++;
    if (rd !== 256'hA) begin n_err++; $display("FAIL post_abort_data got %h want a", rd); end
  endtask

  task automatic test_idle();
    int acks;
    int bad;
    @(negedge clk);
    enable = 1'b0;
    acks = 0;
    for (int c = 0; c < 50; c++) begin
      addr = $urandom; data = rand_line(); write = 1'b1;
      @(negedge clk);
      if (ack) acks++;
    end
    n_cmp++;
    if (acks !== 0) begin n_err++; $display("FAIL idle_acks got %0d want 0", acks); end
    bad = 0;
    for (int i = 0; i < 512; i++) if (dut.memory[i] !== ref_mem[i]) bad++;
    n_cmp++;
    if (bad !== 0) begin n_err++; $display("FAIL idle_mem lines_changed got %0d want 0", bad); end
  endtask

  initial begin
    rst = 1'b0; enable = 1'b0; write = 1'b0; addr = '0; data = '0;
    for (int i = 0; i < 512; i++) preload(i, rand_line());
    test_reset();
    test_write();
    test_alias();
    test_back_to_back();
    test_random();
    test_reset_abort();
    test_idle();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
